// File: rtl/flag_reg_unit_pkg.sv
// Shared definitions for the flag register unit: micro-action codes,
// default flag bit positions and default IBus addresses.
package flag_reg_unit_pkg;

   typedef enum logic [3:0] {
      ACT_NOP = 4'd0,
      ACT_CPL = 4'd1,
      ACT_CLL = 4'd2,
      ACT_STI = 4'd3,
      ACT_CLI = 4'd4
   } action_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_BIT_N = 2;
   localparam int DEF_BIT_Z = 3;
   localparam int DEF_BIT_L = 4;
   localparam int DEF_BIT_V = 5;
   localparam int DEF_BIT_I = 7;

   localparam logic [4:0] DEF_RADDR   = 5'b01101;
   localparam logic [4:0] DEF_WADDR_A = 5'b01101;
   localparam logic [4:0] DEF_WADDR_B = 5'b01110;

endpackage

// File: rtl/flag_reg_unit_if.sv
// Microcode/ALU-side signals of the flag register unit; the tri-state
// IBus and front-panel nets stay as plain ports on the top module.
interface flag_reg_unit_if #(
   parameter int WIDTH = 8
);
   logic [4:0]       waddr;
   logic [4:0]       raddr;
   logic [3:0]       action;
   logic [WIDTH-1:0] fupd;
   logic [WIDTH-1:0] fin;
   logic             nfpflags;
   logic             nflagwe;
   logic [WIDTH-1:0] flags;

   modport master (
      output waddr, raddr, action, fupd, fin, nfpflags,
      input  nflagwe, flags
   );

   modport slave (
      input  waddr, raddr, action, fupd, fin, nfpflags,
      output nflagwe, flags
   );
endinterface

// File: rtl/flag_reg_unit_sync2.sv
// Two-flop synchroniser with asynchronous active-high reset to a
// parametric value.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta_reg;
   logic q_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_reg <= RESET_VAL;
         q_reg    <= RESET_VAL;
      end else begin
         meta_reg <= d;
         q_reg    <= meta_reg;
      end
   end

   assign q = q_reg;
endmodule

// File: rtl/flag_reg_unit.sv
// Processor flag register: bus load, micro-actions and per-bit ALU updates,
// with IBus read-back and a strobe-stable front-panel snapshot.
module flag_reg_unit
   import flag_reg_unit_pkg::*;
#(
   parameter int         WIDTH   = DEF_WIDTH,
   parameter int         BIT_N   = DEF_BIT_N,
   parameter int         BIT_Z   = DEF_BIT_Z,
   parameter int         BIT_L   = DEF_BIT_L,
   parameter int         BIT_V   = DEF_BIT_V,
   parameter int         BIT_I   = DEF_BIT_I,
   parameter logic [4:0] RADDR   = DEF_RADDR,
   parameter logic [4:0] WADDR_A = DEF_WADDR_A,
   parameter logic [4:0] WADDR_B = DEF_WADDR_B
) (
   input  logic             clk4,
   input  logic             reset,
   flag_reg_unit_if.slave   bus,
   inout  wire  [WIDTH-1:0] ibus,
   output wire  [WIDTH-1:0] fpd
);
   localparam logic [WIDTH-1:0] FLAG_MASK =
      WIDTH'((1 << BIT_N) | (1 << BIT_Z) | (1 << BIT_L) | (1 << BIT_V) | (1 << BIT_I));

   logic [WIDTH-1:0] word_reg;
   logic [WIDTH-1:0] word_next;
   logic [WIDTH-1:0] upd_en;
   logic [WIDTH-1:0] alu_word;
   logic [WIDTH-1:0] snap_reg;
   logic             strobe_sync;
   logic             write_en;
   logic             read_en;

   assign write_en    = (bus.waddr == WADDR_A) || (bus.waddr == WADDR_B);
   assign read_en     = (bus.raddr == RADDR);
   assign bus.nflagwe = ~write_en;
   assign bus.flags   = word_reg & FLAG_MASK;

   assign ibus = read_en ? (word_reg & FLAG_MASK) : {WIDTH{1'bz}};
   assign fpd  = bus.nfpflags ? {WIDTH{1'bz}} : snap_reg;

   // Unmapped positions never enable an update, so they keep their zero.
   assign upd_en   = bus.fupd & FLAG_MASK;
   assign alu_word = (word_reg & ~upd_en) | (bus.fin & upd_en);

   // Actions are applied on top of the ALU result so the touched bit wins.
   always_comb begin
      word_next = alu_word;
      if (write_en) begin
         word_next = ibus & FLAG_MASK;
      end else begin
         case (bus.action)
            ACT_CPL: word_next[BIT_L] = ~word_reg[BIT_L];
            ACT_CLL: word_next[BIT_L] = 1'b0;
            ACT_STI: word_next[BIT_I] = 1'b1;
            ACT_CLI: word_next[BIT_I] = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk4 or posedge reset) begin
      if (reset) begin
         word_reg <= '0;
      end else begin
         word_reg <= word_next;
      end
   end

   sync2 #(
      .RESET_VAL(1'b1)
   ) u_sync2 (
      .clk (clk4),
      .rst (reset),
      .d   (bus.nfpflags),
      .q   (strobe_sync)
   );

   // Snapshot tracks the word until the synchronised strobe goes low.
   always_ff @(posedge clk4 or posedge reset) begin
      if (reset) begin
         snap_reg <= '0;
      end else if (strobe_sync) begin
         snap_reg <= word_reg & FLAG_MASK;
      end
   end
endmodule

// File: tb/tb_flag_reg_unit.sv
// Directed and randomised check of flag_reg_unit against a flag-rule model.
// Bench nets are pulled high, so a released tri-state bus reads 8'hFF.
module tb_flag_reg_unit;
   localparam logic [7:0] MASK  = 8'hBC;
   localparam logic [7:0] ZPULL = 8'hFF;

   logic clk4  = 1'b0;
   logic reset = 1'b0;
   logic [7:0] ibus_drv = 8'h00;
   logic       ibus_oe  = 1'b0;
   tri1  [7:0] ibus;
   tri1  [7:0] fpd;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] model_word = 8'h00;
   logic [7:0] model_snap = 8'h00;
   logic       strobe_prev1 = 1'b1;
   logic       strobe_prev2 = 1'b1;

   assign ibus = ibus_oe ? ibus_drv : 8'hzz;

   flag_reg_unit_if #(.WIDTH(8)) bus ();

   flag_reg_unit dut (
      .clk4  (clk4),
      .reset (reset),
      .bus   (bus),
      .ibus  (ibus),
      .fpd   (fpd)
   );

   always #5 clk4 = ~clk4;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] flag_rules(input logic [7:0] word, input logic [4:0] waddr,
                                             input logic [7:0] bus_val, input logic [3:0] action,
                                             input logic [7:0] fupd, input logic [7:0] fin);
      logic [7:0] w;
      if (waddr == 5'd13 || waddr == 5'd14) return bus_val & MASK;
      w = word;
      for (int b = 0; b < 8; b++)
         if (MASK[b] && fupd[b]) w[b] = fin[b];
      case (action)
         4'd1: w[4] = ~word[4];
         4'd2: w[4] = 1'b0;
         4'd3: w[7] = 1'b1;
         4'd4: w[7] = 1'b0;
         default: ;
      endcase
      return w;
   endfunction

   task automatic model_reset();
      model_word   = 8'h00;
      model_snap   = 8'h00;
      strobe_prev1 = 1'b1;
      strobe_prev2 = 1'b1;
   endtask

   // One clock edge with the inputs currently applied; checks before and after.
   task automatic step(input string tag);
      logic exp_we;
      #1;
      exp_we = !(bus.waddr == 5'd13 || bus.waddr == 5'd14);
      check({tag, ".nflagwe"}, {7'b0, bus.nflagwe}, {7'b0, exp_we});
      @(posedge clk4);
      // The panel sees the word from before this edge only if the strobe was
      // still high two edges ago.
      if (strobe_prev2) model_snap = model_word;
      strobe_prev2 = strobe_prev1;
      strobe_prev1 = bus.nfpflags;
      model_word = flag_rules(model_word, bus.waddr, ibus_drv, bus.action, bus.fupd, bus.fin);
      #1;
      check({tag, ".flags"}, bus.flags, model_word);
      check({tag, ".fpd"}, fpd, bus.nfpflags ? ZPULL : model_snap);
      if (bus.raddr == 5'd13 && !ibus_oe)
         check({tag, ".ibus"}, ibus, model_word);
   endtask

   task automatic idle_inputs();
      bus.waddr  = 5'd0;
      bus.raddr  = 5'd0;
      bus.action = 4'd0;
      bus.fupd   = 8'h00;
      bus.fin    = 8'h00;
      ibus_oe    = 1'b0;
      ibus_drv   = 8'h00;
   endtask

   initial begin
      logic [7:0] frozen;
      idle_inputs();
      bus.nfpflags = 1'b1;

      // Reset
      #1 reset = 1'b1;
      #1;
      model_reset();
      check("reset.flags", bus.flags, 8'h00);
      check("reset.fpd", fpd, ZPULL);
      @(posedge clk4);
      @(posedge clk4);
      #1 reset = 1'b0;
      check("post_reset.flags", bus.flags, 8'h00);

      // Read-address and write-address decode sweeps
      for (int r = 0; r < 32; r++) begin
         bus.raddr = 5'(r);
         #1;
         check($sformatf("raddr_sweep[%0d]", r), ibus, (r == 13) ? 8'h00 : ZPULL);
      end
      bus.raddr = 5'd0;
      ibus_oe   = 1'b1;
      ibus_drv  = 8'h00;
      for (int w = 0; w < 32; w++) begin
         bus.waddr = 5'(w);
         #1;
         check($sformatf("waddr_sweep[%0d]", w), {7'b0, bus.nflagwe},
               (w == 13 || w == 14) ? 8'h00 : 8'h01);
      end
      idle_inputs();
      @(posedge clk4);
      #1;

      // Bus writes
      bus.waddr = 5'd14; ibus_oe = 1'b1; ibus_drv = 8'hFF;
      step("write_ff");
      check("write_ff.const", bus.flags, 8'hBC);
      idle_inputs();
      bus.raddr = 5'd13;
      #1 check("read_bc", ibus, 8'hBC);
      bus.raddr = 5'd0;
      bus.waddr = 5'd14; ibus_oe = 1'b1; ibus_drv = 8'h43;
      step("write_43");
      check("write_43.const", bus.flags, 8'h00);
      idle_inputs();

      // Micro-actions
      bus.action = 4'd3; step("sti"); check("sti.const", bus.flags, 8'h80);
      bus.action = 4'd1; step("cpl1"); check("cpl1.const", bus.flags, 8'h90);
      bus.action = 4'd1; step("cpl2"); check("cpl2.const", bus.flags, 8'h80);
      bus.action = 4'd2; step("cll"); check("cll.const", bus.flags, 8'h80);
      bus.action = 4'd4; step("cli"); check("cli.const", bus.flags, 8'h00);

      // Simultaneous events: write beats action and ALU, action beats ALU
      bus.waddr = 5'd13; ibus_oe = 1'b1; ibus_drv = 8'h00;
      bus.action = 4'd3; bus.fupd = 8'hFF; bus.fin = 8'hFF;
      step("wr_prio"); check("wr_prio.const", bus.flags, 8'h00);
      bus.waddr = 5'd0; ibus_oe = 1'b0;
      bus.action = 4'd2; bus.fupd = 8'hFF; bus.fin = 8'hFF;
      step("act_prio"); check("act_prio.const", bus.flags, 8'hAC);
      idle_inputs();

      // Front-panel strobe while L toggles every cycle
      bus.nfpflags = 1'b0;
      bus.action   = 4'd1;
      step("fp1");
      step("fp2");
      frozen = fpd;
      step("fp3"); check("fp3.stable", fpd, frozen);
      step("fp4"); check("fp4.stable", fpd, frozen);
      bus.nfpflags = 1'b1;
      bus.action   = 4'd0;
      #1 check("fp_release", fpd, ZPULL);
      step("fp_idle");

      // Reset asserted mid-strobe
      bus.waddr = 5'd14; ibus_oe = 1'b1; ibus_drv = 8'hFF;
      step("pre_rst_write");
      idle_inputs();
      bus.nfpflags = 1'b0;
      step("rst_fp1");
      step("rst_fp2");
      step("rst_fp3");
      check("rst_fp.frozen", fpd, 8'hBC);
      #1 reset = 1'b1;
      #1;
      model_reset();
      check("rst_mid.flags", bus.flags, 8'h00);
      check("rst_mid.fpd", fpd, 8'h00);
      @(posedge clk4);
      #1 reset = 1'b0;
      bus.nfpflags = 1'b1;
      step("rst_release");

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         logic writing;
         case ($urandom_range(0, 3))
            0:       bus.waddr = 5'd13;
            1:       bus.waddr = 5'd14;
            default: bus.waddr = 5'($urandom_range(0, 31));
         endcase
         writing    = (bus.waddr == 5'd13 || bus.waddr == 5'd14);
         bus.raddr  = 5'($urandom_range(0, 31));
         if (writing && bus.raddr == 5'd13) bus.raddr = 5'd12;
         bus.action = 4'($urandom_range(0, 15));
         bus.fupd   = 8'($urandom);
         bus.fin    = 8'($urandom);
         ibus_drv   = 8'($urandom);
         ibus_oe    = writing ? 1'b1 : ((bus.raddr != 5'd13) && $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 5) == 0) bus.nfpflags = ~bus.nfpflags;
         step($sformatf("rand[%0d]", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
